// File: rtl/chunked_addsub.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock and threads the carry
// between chunks through a register. start/busy/done handshake, signed-overflow output.
module chunked_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("chunked_addsub: WIDTH must be an integer multiple of CHUNK");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [CHUNK-1:0]  ch_a, ch_b, ch_s;
    logic              ch_cin, ch_cmsb, ch_cout, rc;
    logic [WIDTH-1:0]  res_full;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Single-chunk configuration adds straight from the ports on the start edge.
        if (NCHUNK == 1) begin
            ch_a   = A[CHUNK-1:0];
            ch_b   = sub ? ~B[CHUNK-1:0] : B[CHUNK-1:0];
            ch_cin = sub;
        end else begin
            ch_a   = op_a_q[CHUNK-1:0];
            ch_b   = op_b_q[CHUNK-1:0];
            ch_cin = carry_q;
        end

        ch_s    = '0;
        ch_cmsb = 1'b0;
        rc      = ch_cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            ch_cmsb = rc;
            ch_s[i] = ch_a[i] ^ ch_b[i] ^ rc;
            rc      = (ch_a[i] & ch_b[i]) | (ch_a[i] & rc) | (ch_b[i] & rc);
        end
        ch_cout = rc;

        // Operands shift down each cycle; the accumulator fills from the top, so after
        // NCHUNK cycles chunk k sits at bits k*CHUNK.
        res_full = (acc_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (NCHUNK == 1) begin
                        sum_d  = WIDTH'(ch_s);
                        cout_d = ch_cout;
                        ovf_d  = ch_cmsb ^ ch_cout;
                        done_d = 1'b1;
                    end else begin
                        op_a_d  = A;
                        op_b_d  = sub ? ~B : B;
                        carry_d = sub;
                        idx_d   = '0;
                        acc_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                op_a_d  = op_a_q >> CHUNK;
                op_b_d  = op_b_q >> CHUNK;
                carry_d = ch_cout;
                acc_d   = res_full;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NCHUNK - 1)) begin
                    sum_d   = res_full;
                    cout_d  = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == StRun);
    assign done     = done_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: CHUNK=4 directed + random, plus CHUNK=16 and CHUNK=1
// instances fed random vectors against an integer-arithmetic reference model.
module tb_chunked_addsub;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Main instance (CHUNK=4)
    logic        start = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [15:0] sum;
    logic        cout, ovf, busy, done;

    // Sweep instances share one stimulus
    logic        s_start = 1'b0, s_sub = 1'b0;
    logic [15:0] s_a = '0, s_b = '0;
    logic [15:0] sum16, sum1;
    logic        cout16, ovf16, busy16, done16;
    logic        cout1, ovf1, busy1, done1;

    exp_t q_main[$];
    exp_t q_c16[$];
    exp_t q_c1[$];
    exp_t hold;

    chunked_addsub #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .A(a), .B(b),
        .sum(sum), .cout(cout), .overflow(ovf), .busy(busy), .done(done)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(s_start), .sub(s_sub), .A(s_a), .B(s_b),
        .sum(sum16), .cout(cout16), .overflow(ovf16), .busy(busy16), .done(done16)
    );

    chunked_addsub #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(s_start), .sub(s_sub), .A(s_a), .B(s_b),
        .sum(sum1), .cout(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                   input int done_cyc);
        exp_t m;
        int sx, sy, ux, uy, r, ur;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'({16'h0, x});
        uy = int'({16'h0, y});
        r  = s ? sx - sy : sx + sy;
        ur = s ? ux - uy : ux + uy;
        m.sum  = ur[15:0];
        m.cout = s ? (ux >= uy) : (ur > 65535);
        m.ovf  = (r > 32767) || (r < -32768);
        m.cyc  = done_cyc;
        return m;
    endfunction

    // Monitors sample 2 time units after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            check("rst_sum", 32'(sum), 32'h0);
            check("rst_cout", 32'(cout), 32'h0);
            check("rst_ovf", 32'(ovf), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_done", 32'(done), 32'h0);
            q_main.delete();
            hold = '{sum: 16'h0, cout: 1'b0, ovf: 1'b0, cyc: 0};
        end else if (done) begin
            check("done_expected", 32'(q_main.size() != 0), 32'h1);
            if (q_main.size() != 0) begin
                e = q_main.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("busy_at_done", 32'(busy), 32'h0);
                hold = e;
            end
        end else begin
            check("hold_sum", 32'(sum), 32'(hold.sum));
            check("hold_flags", 32'({cout, ovf}), 32'({hold.cout, hold.ovf}));
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            q_c16.delete();
        end else begin
            check("c16_busy_never", 32'(busy16), 32'h0);
            if (done16) begin
                check("c16_done_expected", 32'(q_c16.size() != 0), 32'h1);
                if (q_c16.size() != 0) begin
                    e = q_c16.pop_front();
                    check("c16_sum", 32'(sum16), 32'(e.sum));
                    check("c16_flags", 32'({cout16, ovf16}), 32'({e.cout, e.ovf}));
                end
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (reset) begin
            q_c1.delete();
        end else if (done1) begin
            check("c1_done_expected", 32'(q_c1.size() != 0), 32'h1);
            if (q_c1.size() != 0) begin
                e = q_c1.pop_front();
                check("c1_sum", 32'(sum1), 32'(e.sum));
                check("c1_flags", 32'({cout1, ovf1}), 32'({e.cout, e.ovf}));
                check("c1_done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drives one accepted op on the main instance; returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub = s; start = 1'b1;
        q_main.push_back(model(x, y, s, cyc + 1 + 4));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || q_main.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < 100), 32'h1);
    endtask

    task automatic issue_sweep(input logic [15:0] x, input logic [15:0] y, input logic s);
        int k = 0;
        @(negedge clk);
        s_a = x; s_b = y; s_sub = s; s_start = 1'b1;
        q_c16.push_back(model(x, y, s, cyc + 1));
        q_c1.push_back(model(x, y, s, cyc + 1 + 16));
        @(negedge clk);
        s_start = 1'b0;
        while ((busy1 || q_c1.size() != 0 || q_c16.size() != 0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("sweep_timeout", 32'(k < 60), 32'h1);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Basic add with busy-window check
        issue(16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("busy_window", 32'(busy), 32'h1);
            @(negedge clk);
        end
        check("busy_after", 32'(busy), 32'h0);
        check("done_after_4", 32'(done), 32'h1);
        wait_idle("t1_timeout");

        issue(16'hFFFF, 16'h0001, 1'b0); wait_idle("t2a_timeout");
        issue(16'h7FFF, 16'h0001, 1'b0); wait_idle("t2b_timeout");
        issue(16'h0005, 16'h0007, 1'b1); wait_idle("t3a_timeout");
        issue(16'h8000, 16'h0001, 1'b1); wait_idle("t3b_timeout");

        // start while busy must be ignored
        issue(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t4a_timeout");
        repeat (6) @(negedge clk);

        // Back-to-back: start on the done cycle
        issue(16'h0F0F, 16'h00F1, 1'b0);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t4b_done_seen", 32'(k < 20), 32'h1);
        a = 16'hA5A5; b = 16'h5A5B; sub = 1'b1; start = 1'b1;
        q_main.push_back(model(16'hA5A5, 16'h5A5B, 1'b1, cyc + 1 + 4));
        @(negedge clk);
        start = 1'b0;
        wait_idle("t4b_timeout");

        // Reset while idx=2 is in flight; the monitor flushes the pending entry
        issue(16'h4444, 16'h3333, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(16'h0102, 16'h0304, 1'b0); wait_idle("t5_timeout");

        // Reset and start together: start dropped
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a = 16'h0F00; b = 16'h00F0; sub = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_start_no_busy", 32'(busy), 32'h0);

        // Random ops on the main instance
        for (int i = 0; i < 30; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            wait_idle("rand_timeout");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Parameter sweep: CHUNK=16 and CHUNK=1
        issue_sweep(16'hFFFF, 16'h0001, 1'b0);
        issue_sweep(16'h8000, 16'h0001, 1'b1);
        for (int i = 0; i < 20; i++) begin
            issue_sweep(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("main_queue_empty", 32'(q_main.size()), 32'h0);
        check("sweep_queues_empty", 32'(q_c16.size() + q_c1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised multi-cycle ripple adder/subtractor. Successor to the fixed-width combinational adders in the lab datapath.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, threading the carry between chunks through a register. This trades latency for a short critical path.
- Adds subtract mode, signed-overflow detection and a start/busy/done handshake. Feeds the ALU/accumulator stage.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per cycle. WIDTH must be an integer multiple of CHUNK; elaboration error otherwise.
- NCHUNK, WIDTH/CHUNK, derived (localparam), number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = A+B, 1 = A-B; captured with start.
- A  input  WIDTH  first operand; captured with start.
- B  input  WIDTH  second operand; captured with start.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of MSB (subtract: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when sum/cout/overflow update.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Reset: state=IDLE. sum, cout, overflow, busy and done all 0. Internal operand regs, chunk index and carry reg are 0.
- FSM states:
  - IDLE: on an edge with start=1, capture opA=A, opB = sub ? ~B : B, carry=sub, idx=0. Go to RUN; busy=1 from the next cycle.
  - RUN: each edge adds chunk idx (bits idx*CHUNK+:CHUNK) of opA, opB and carry using a CHUNK-bit ripple of full adders. Writes the chunk into the internal accumulator and updates carry. On the MSB chunk (idx=NCHUNK-1), also records the carry into bit WIDTH-1. idx increments.
  - Completion: the edge that processes idx=NCHUNK-1 also loads sum from the accumulator, sets cout=final carry and overflow=carry_into_MSB XOR carry_out_of_MSB. It pulses done=1 for exactly one cycle, clears busy and returns to IDLE.
- Latency: start sampled at edge t; done and result visible after edge t+NCHUNK. NCHUNK=1 gives single-cycle operation with busy never asserted.
- Back-to-back: start may be asserted in the same cycle done=1 (state is IDLE then). The new operation is accepted, giving a throughput of one op per NCHUNK cycles.
- start while busy=1: ignored. A, B and sub are not resampled, and the in-flight operation is unaffected.
- sum, cout and overflow change only on a completion edge or reset. They never show partial chunks.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- reset during RUN: the operation is aborted, no done pulse is produced, and all outputs go to 0 on that edge.
- reset and start in the same cycle: reset wins and the start is dropped.

Test Plan (WIDTH=16, CHUNK=4 unless noted):
1. Basic add and latency: start, A=0x1234, B=0x4321, sub=0 -> busy high 4 cycles, done pulse one cycle after 4th edge, sum=0x5555, cout=0, overflow=0.
2. Carry across every chunk boundary: A=0xFFFF, B=0x0001 add -> sum=0x0000, cout=1, overflow=0. Then A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, overflow=1.
3. Subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0, overflow=0. Then A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1.
4. Handshake: start again with A=0x0001 two cycles into an op -> ignored, result matches the first op. Start asserted on the done cycle -> second op accepted, its done comes exactly 4 cycles later.
5. Reset: assert reset at RUN idx=2 -> no done pulse, sum, cout, overflow, busy all 0 next cycle. A fresh start afterwards completes normally.
6. Parameter sweep: CHUNK=16 (1 cycle, busy never high) and CHUNK=1 (16 cycles) -> random A, B, sub vectors match a reference model for sum, cout and overflow.
